// File: rtl/vf_frame_scheduler_if.sv
// Camera fetch port plus both pixel-source ports of the frame scheduler.
// master = camera core / pixel generators side, slave = scheduler side.
interface vf_frame_scheduler_if;
   logic       vf_sof;
   logic       vf_req;
   logic [7:0] vf_byte;
   logic [1:0] src_rdy;
   logic [1:0] src_sof;
   logic [1:0] src_req;
   logic [7:0] src_byte0;
   logic [7:0] src_byte1;
   logic [1:0] src_valid;

   modport master (
      output vf_sof, vf_req, src_rdy, src_byte0, src_byte1, src_valid,
      input  vf_byte, src_sof, src_req
   );

   modport slave (
      input  vf_sof, vf_req, src_rdy, src_byte0, src_byte1, src_valid,
      output vf_byte, src_sof, src_req
   );
endinterface

// File: rtl/vf_frame_scheduler.sv
// Frame-level arbiter between the UVC camera frame fetch port and two pixel
// sources; grant held per frame, fill byte substituted for missing data.
module vf_frame_scheduler #(
   parameter int         FRAME_W   = 252,
   parameter int         FRAME_H   = 120,
   parameter int         BPP       = 1,
   parameter logic [7:0] FILL_BYTE = 8'h10
) (
   input  logic                 clk,
   input  logic                 rst,
   vf_frame_scheduler_if.slave  bus,
   input  logic [1:0]           mode,
   output logic                 active_src,
   output logic                 grant_vld,
   output logic [15:0]          frame_cnt,
   output logic [15:0]          fill_cnt,
   output logic                 err_short,
   output logic                 err_over
);
   localparam logic [28:0] TOTAL    = 29'(FRAME_W * FRAME_H * BPP);
   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_STREAM = 2'd1;
   localparam logic [1:0]  S_DONE   = 2'd2;

   logic [1:0]  state;
   logic [28:0] byte_cnt;
   logic        last;
   logic        gnt_ok, gnt_idx;
   logic        cur_stream, cur_vld, cur_idx;
   logic        dq, fill_q, fill_now;
   logic [7:0]  src_sel;

   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = 1'b0;
      case (mode)
         2'b00: gnt_ok = bus.src_rdy[0];
         2'b01: begin
            gnt_ok  = bus.src_rdy[1];
            gnt_idx = 1'b1;
         end
         2'b10: begin
            if (bus.src_rdy[~last]) begin
               gnt_ok  = 1'b1;
               gnt_idx = ~last;
            end else if (bus.src_rdy[last]) begin
               gnt_ok  = 1'b1;
               gnt_idx = last;
            end
         end
         default: begin
            if (bus.src_rdy[0]) begin
               gnt_ok = 1'b1;
            end else if (bus.src_rdy[1]) begin
               gnt_ok  = 1'b1;
               gnt_idx = 1'b1;
            end
         end
      endcase
   end

   // A request coincident with vf_sof already belongs to the new frame and grant.
   assign cur_stream = bus.vf_sof | (state == S_STREAM);
   assign cur_vld    = bus.vf_sof ? gnt_ok  : grant_vld;
   assign cur_idx    = bus.vf_sof ? gnt_idx : active_src;

   assign bus.src_sof = {2{bus.vf_sof & gnt_ok}} & (gnt_idx ? 2'b10 : 2'b01);
   assign bus.src_req = {2{bus.vf_req & cur_stream & cur_vld}} & (cur_idx ? 2'b10 : 2'b01);

   assign src_sel     = active_src ? bus.src_byte1 : bus.src_byte0;
   assign fill_now    = fill_q | ~bus.src_valid[active_src];
   assign bus.vf_byte = fill_now ? FILL_BYTE : src_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_cnt   <= '0;
         active_src <= 1'b0;
         grant_vld  <= 1'b0;
         last       <= 1'b0;
         frame_cnt  <= '0;
         fill_cnt   <= '0;
         err_short  <= 1'b0;
         err_over   <= 1'b0;
         dq         <= 1'b0;
         fill_q     <= 1'b1;
      end else begin
         dq        <= bus.vf_req;
         fill_q    <= ~(cur_stream & cur_vld);
         err_short <= bus.vf_sof & (state == S_STREAM);
         err_over  <= bus.vf_req & ~bus.vf_sof & (state == S_DONE);
         if (bus.vf_sof) begin
            active_src <= gnt_idx;
            grant_vld  <= gnt_ok;
            if (gnt_ok) last <= gnt_idx;
            frame_cnt  <= frame_cnt + 16'd1;
            fill_cnt   <= '0;
            byte_cnt   <= {28'd0, bus.vf_req};
            state      <= (bus.vf_req && TOTAL == 29'd1) ? S_DONE : S_STREAM;
         end else begin
            if (dq && fill_now && fill_cnt != 16'hFFFF) fill_cnt <= fill_cnt + 16'd1;
            if (state == S_STREAM && bus.vf_req) begin
               byte_cnt <= byte_cnt + 29'd1;
               if (byte_cnt + 29'd1 == TOTAL) state <= S_DONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_vf_frame_scheduler.sv
// Directed bench for vf_frame_scheduler: reset, grant policies, fill bytes,
// frame-length errors and mid-frame reset.
module tb_vf_frame_scheduler;
   localparam int TOTAL = 252 * 120 * 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic        active_src, grant_vld, err_short, err_over;
   logic [15:0] frame_cnt, fill_cnt;

   vf_frame_scheduler_if ifc ();

   vf_frame_scheduler dut (
      .clk(clk), .rst(rst), .bus(ifc), .mode(mode),
      .active_src(active_src), .grant_vld(grant_vld),
      .frame_cnt(frame_cnt), .fill_cnt(fill_cnt),
      .err_short(err_short), .err_over(err_over)
   );

   always #8 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Pixel sources: registered byte one cycle after src_req, distinct byte ranges.
   logic [1:0] valid_en;
   logic [7:0] s0_ctr, s1_ctr;
   always @(posedge clk) begin
      if (rst) begin
         s0_ctr        <= 8'd0;
         s1_ctr        <= 8'd0;
         ifc.src_byte0 <= 8'h00;
         ifc.src_byte1 <= 8'h00;
      end else begin
         if (ifc.src_req[0]) begin
            ifc.src_byte0 <= {2'b10, s0_ctr[5:0]};
            s0_ctr        <= s0_ctr + 8'd1;
         end
         if (ifc.src_req[1]) begin
            ifc.src_byte1 <= {2'b11, s1_ctr[5:0]};
            s1_ctr        <= s1_ctr + 8'd1;
         end
      end
      ifc.src_valid <= valid_en;
   end

   int n_req0 = 0, n_req1 = 0, n_short = 0, n_over = 0;
   always @(posedge clk) begin
      if (ifc.src_req[0]) n_req0 <= n_req0 + 1;
      if (ifc.src_req[1]) n_req1 <= n_req1 + 1;
      if (err_short)      n_short <= n_short + 1;
      if (err_over)       n_over <= n_over + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic sof(input logic [1:0] m, input logic [1:0] rdy);
      mode = m; ifc.src_rdy = rdy; ifc.vf_sof = 1'b1;
      @(negedge clk);
      ifc.vf_sof = 1'b0;
   endtask

   int          bad, fills, base_r0, base_r1, base_s, base_o;
   logic [7:0]  b, expb;

   initial begin
      rst = 1'b1; mode = 2'b00; valid_en = 2'b11;
      ifc.vf_sof = 1'b0; ifc.vf_req = 1'b0; ifc.src_rdy = 2'b00;
      cyc(3);
      // Reset state
      chk("rst_vf_byte", ifc.vf_byte, 8'h10);
      chk("rst_grant_vld", grant_vld, 0);
      chk("rst_active_src", active_src, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_fill_cnt", fill_cnt, 0);
      chk("rst_err", {err_short, err_over}, 0);
      chk("rst_src_req_sof", {ifc.src_req, ifc.src_sof}, 0);
      rst = 1'b0;
      cyc(1);

      // Request in IDLE: fill byte, no overrun error
      ifc.vf_req = 1'b1; cyc(1); ifc.vf_req = 1'b0;
      chk("idle_byte", ifc.vf_byte, 8'h10);
      chk("idle_no_over", err_over, 0);
      cyc(1);

      // Mode 00, src_rdy=01, one full frame
      base_r0 = n_req0; base_r1 = n_req1; base_s = n_short; base_o = n_over;
      mode = 2'b00; ifc.src_rdy = 2'b01; ifc.vf_sof = 1'b1;
      #1 chk("m00_src_sof", ifc.src_sof, 2'b01);
      @(negedge clk); ifc.vf_sof = 1'b0;
      chk("m00_grant", {grant_vld, active_src}, 2'b10);
      chk("m00_frame_cnt", frame_cnt, 1);
      b = s0_ctr; bad = 0;
      for (int i = 0; i < TOTAL; i++) begin
         ifc.vf_req = 1'b1;
         @(negedge clk);
         expb = {2'b10, b[5:0]};
         if (ifc.vf_byte !== expb) bad++;
         b = b + 8'd1;
      end
      ifc.vf_req = 1'b0;
      cyc(1);
      chk("m00_bytes_bad", bad, 0);
      chk("m00_req0", n_req0 - base_r0, TOTAL);
      chk("m00_req1", n_req1 - base_r1, 0);
      chk("m00_errs", (n_short - base_s) + (n_over - base_o), 0);
      chk("m00_fill_cnt", fill_cnt, 0);

      // One request past the end: fill byte, err_over once, no src_req
      ifc.vf_req = 1'b1; cyc(1); ifc.vf_req = 1'b0;
      chk("over_byte", ifc.vf_byte, 8'h10);
      chk("over_pulse", err_over, 1);
      cyc(1);
      chk("over_one_cycle", err_over, 0);
      chk("over_fill_cnt", fill_cnt, 1);
      chk("over_no_src_req", n_req0 - base_r0, TOTAL);
      sof(2'b00, 2'b01);
      chk("sof_from_done_no_short", err_short, 0);
      ifc.vf_req = 1'b1; cyc(100); ifc.vf_req = 1'b0;
      sof(2'b00, 2'b01);
      chk("short_pulse", err_short, 1);
      cyc(1);
      chk("short_one_cycle", err_short, 0);
      cyc(1);
      chk("over_count", n_over - base_o, 1);
      chk("short_count", n_short - base_s, 1);
      chk("frame_cnt_3", frame_cnt, 3);

      // Round robin with both sources ready over 4 frames
      rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
      base_s = n_short; base_r1 = n_req1;
      for (int f = 0; f < 3; f++) begin
         sof(2'b10, 2'b11);
         chk($sformatf("rr_grant_f%0d", f), {grant_vld, active_src}, (f % 2 == 0) ? 2'b11 : 2'b10);
         ifc.vf_req = 1'b1; cyc(3); ifc.vf_req = 1'b0;
      end
      // Fourth frame: vf_sof and vf_req together go to the new grant
      b = s0_ctr;
      mode = 2'b10; ifc.src_rdy = 2'b11; ifc.vf_sof = 1'b1; ifc.vf_req = 1'b1;
      #1 chk("rr_same_cycle_req", ifc.src_req, 2'b01);
      @(negedge clk); ifc.vf_sof = 1'b0; ifc.vf_req = 1'b0;
      chk("rr_grant_f3", {grant_vld, active_src}, 2'b10);
      chk("rr_same_cycle_byte", ifc.vf_byte, {2'b10, b[5:0]});
      cyc(2);
      chk("rr_frame_cnt", frame_cnt, 4);
      chk("rr_short_count", n_short - base_s, 3);
      chk("rr_req1", n_req1 - base_r1, 6);

      // src_valid dropped for 5 data cycles mid-frame
      sof(2'b00, 2'b01);
      b = s0_ctr; bad = 0; fills = 0;
      for (int i = 0; i < 20; i++) begin
         valid_en = (i >= 8 && i <= 12) ? 2'b10 : 2'b11;
         ifc.vf_req = 1'b1;
         @(negedge clk);
         expb = (i >= 8 && i <= 12) ? 8'h10 : {2'b10, b[5:0]};
         if (ifc.vf_byte !== expb) bad++;
         if (ifc.vf_byte === 8'h10) fills++;
         b = b + 8'd1;
      end
      ifc.vf_req = 1'b0; valid_en = 2'b11;
      cyc(1);
      chk("drop_bytes_bad", bad, 0);
      chk("drop_fill_bytes", fills, 5);
      chk("drop_fill_cnt", fill_cnt, 5);

      // Reset mid-frame with a request in flight
      ifc.vf_req = 1'b1; cyc(2);
      rst = 1'b1;
      cyc(1);
      chk("mrst_vf_byte", ifc.vf_byte, 8'h10);
      chk("mrst_src_req", ifc.src_req, 0);
      chk("mrst_grant", {grant_vld, active_src}, 0);
      chk("mrst_cnts", {frame_cnt, fill_cnt}, 0);
      chk("mrst_err", {err_short, err_over}, 0);
      ifc.vf_req = 1'b0; rst = 1'b0;
      cyc(1);

      // Mode 11 with nothing ready: whole frame is fill
      base_r0 = n_req0; base_r1 = n_req1;
      mode = 2'b11; ifc.src_rdy = 2'b00; ifc.vf_sof = 1'b1;
      #1 chk("none_src_sof", ifc.src_sof, 0);
      @(negedge clk); ifc.vf_sof = 1'b0;
      chk("none_grant_vld", grant_vld, 0);
      bad = 0;
      for (int i = 0; i < TOTAL; i++) begin
         ifc.vf_req = 1'b1;
         @(negedge clk);
         if (ifc.vf_byte !== 8'h10) bad++;
      end
      ifc.vf_req = 1'b0;
      cyc(1);
      chk("none_bytes_bad", bad, 0);
      chk("none_fill_cnt", fill_cnt, TOTAL);
      chk("none_no_src_req", (n_req0 - base_r0) + (n_req1 - base_r1), 0);

      // Remaining grant policies
      sof(2'b11, 2'b10);
      chk("prio_src1", {grant_vld, active_src}, 2'b11);
      sof(2'b11, 2'b11);
      chk("prio_src0", {grant_vld, active_src}, 2'b10);
      sof(2'b01, 2'b01);
      chk("m01_not_ready", grant_vld, 0);
      sof(2'b01, 2'b10);
      chk("m01_grant", {grant_vld, active_src}, 2'b11);
      sof(2'b00, 2'b10);
      chk("m00_not_ready", grant_vld, 0);
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
